ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction-fetch unit with a decoupled prefetch queue, a valid/ready memory request interface, variable-latency response, redirect/flush with stale-response squashing, and per-entry halt detection. It sits between the instruction memory and the decode stage. It replaces the single-register fetch path with a buffered one that tolerates decode stalls and multi-cycle memory.

## Interface
- ADDR_W, 32, PC/address width (≥ 3)
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch address after reset; bits [1:0] must be 0
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- redirect_valid  in  1  branch/jump redirect from execute; flushes the unit
- redirect_pc  in  ADDR_W  redirect target; bits [1:0] ignored and treated as 0
- imem_req_valid  out  1  fetch request
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  ADDR_W  request word address
- imem_resp_valid  in  1  response data valid, one cycle per response
- imem_resp_data  in  32  instruction word
- out_valid  out  1  queue head valid to decode
- out_ready  in  1  decode consumes the head
- out_instr  out  32  head instruction
- out_pc  out  ADDR_W  head PC
- out_halt  out  1  head opcode is illegal (out_valid & head halt flag)
- occupancy  out  $clog2(DEPTH+1)  entries currently in queue

## Operation
- State: fetch_pc; circular queue (instr, pc, halt) with rd/wr pointers and count; outstanding bit; stale bit; req_pc register; halted bit.
- Issue condition: imem_req_valid = !outstanding & !halted & (count < DEPTH). It is derived from registered state only, so it has no combinational path from redirect_valid. imem_req_addr = fetch_pc.
- On acceptance (valid & ready): outstanding←1, req_pc←fetch_pc, fetch_pc←fetch_pc+4 (wraps modulo 2^ADDR_W).
- Only one request is outstanding at a time, including a stale one. No new request issues until the outstanding response returns.
- Response (imem_resp_valid & outstanding):
  - outstanding←0.
  - If stale, the response is discarded and stale←0.
  - Otherwise push {data, req_pc, halt}. halt=1 when data[6:0] is not one of 0110011, 0010011, 0100011, 0000011, 1100011, 1100111, 1101111, 0010111, 0110111.
  - Pushing a halt entry sets halted←1, which stops further issue.
- imem_resp_valid with outstanding=0 is ignored.
- Pop: when out_valid & out_ready, rd_ptr advances and count decrements. Push and pop in the same cycle leave count unchanged.
- Redirect (highest priority):
  - Queue emptied (count←0, pointers←0), halted←0, fetch_pc←{redirect_pc[ADDR_W-1:2],2'b00}.
  - If a request is outstanding, or is accepted in the same cycle, stale←1 and outstanding←1.
  - A response arriving in the same cycle as the redirect is dropped. The outstanding request is then cleared, unless a new request is also accepted that cycle, in which case it becomes the stale one.
  - A pop in the same cycle as the redirect is ignored.
- Credit rule: count + outstanding ≤ DEPTH always holds, so a push never overflows.

## Timing
- While rst=0 on a clock edge: fetch_pc←RESET_PC; count, outstanding, stale, halted←0.
- Outputs during reset: imem_req_valid=0 (held off during the reset cycle); out_valid=0; out_halt=0; occupancy=0; imem_req_addr=RESET_PC.
- First cycle after rst=1: imem_req_valid=1, addr=RESET_PC.
- Response in cycle N → out_valid in N+1. No bypass from response to output.
- Redirect in cycle N:
  - out_valid=0 in N+1.
  - Request for redirect_pc is valid in N+1 if nothing is outstanding, else one cycle after the stale response returns.
- Reset asserted mid-operation discards everything, including outstanding and stale state. Any late response after reset is ignored because outstanding=0.
- With out_ready stuck low, the queue fills to DEPTH and imem_req_valid stays 0. It rises the cycle after the first pop.

## Test plan
- Zero-latency memory (ready=1, resp next cycle), out_ready=1, RESET_PC=0x100 → out_pc sequence 0x100, 0x104, 0x108, …; one instruction per 2 cycles; occupancy ≤ 1.
- out_ready=0 for 20 cycles, DEPTH=4 → occupancy saturates at 4; imem_req_valid=0; then release → four heads in consecutive cycles with correct pc/instr pairs.
- Request accepted at 0x10, 3-cycle response latency, redirect to 0x203 one cycle after acceptance → response for 0x10 discarded; next request addr=0x200 issued the cycle after the stale response; out_pc=0x200 first.
- Response of 0xFFFFFFFF at pc 0x20 → entry pushed with out_halt=1 when at head; no further requests; redirect to 0x40 → halt cleared, fetch resumes at 0x40.
- Redirect, response and pop in the same cycle with 2 queued entries → occupancy 0 next cycle; response dropped; no spurious out_valid.
- rst=0 for 1 cycle while a request is outstanding, then a late imem_resp_valid → ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: one-outstanding memory requester feeding a
// circular prefetch queue, with redirect flush and stale-response squash.
module ifetch_queue #(
   parameter int unsigned          ADDR_W   = 32,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        redirect_valid,
   input  logic [ADDR_W-1:0]           redirect_pc,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [ADDR_W-1:0]           imem_req_addr,
   input  logic                        imem_resp_valid,
   input  logic [31:0]                 imem_resp_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [31:0]                 out_instr,
   output logic [ADDR_W-1:0]           out_pc,
   output logic                        out_halt,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] req_pc_q, req_pc_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              outst_q, outst_d;
   logic              stale_q, stale_d;
   logic              halted_q, halted_d;

   logic [31:0]       instr_q [DEPTH];
   logic [ADDR_W-1:0] pc_q    [DEPTH];
   logic [DEPTH-1:0]  halt_q;

   logic acc, rsp, pop, push, rsp_halt;

   function automatic logic illegal_op(input logic [6:0] op);
      unique case (op)
         7'b0110011, 7'b0010011, 7'b0100011,
         7'b0000011, 7'b1100011, 7'b1100111,
         7'b1101111, 7'b0010111, 7'b0110111: illegal_op = 1'b0;
         default:                            illegal_op = 1'b1;
      endcase
   endfunction

   // Outputs are forced to their reset values while rst is held low.
   assign imem_req_valid = rst & ~outst_q & ~halted_q & (count_q < FULL);
   assign imem_req_addr  = rst ? fetch_pc_q : RESET_PC;
   assign out_valid      = rst & (count_q != '0);
   assign out_instr      = instr_q[rd_ptr_q];
   assign out_pc         = pc_q[rd_ptr_q];
   assign out_halt       = out_valid & halt_q[rd_ptr_q];
   assign occupancy      = rst ? count_q : '0;

   assign acc      = imem_req_valid & imem_req_ready;
   assign rsp      = imem_resp_valid & outst_q;
   assign pop      = out_valid & out_ready;
   assign rsp_halt = illegal_op(imem_resp_data[6:0]);

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      outst_d    = outst_q;
      stale_d    = stale_q;
      halted_d   = halted_q;
      push       = 1'b0;

      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ~ADDR_W'(3);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         halted_d   = 1'b0;
         // Any in-flight request, old or just accepted, must be squashed.
         if (acc || (outst_q && !rsp)) begin
            outst_d = 1'b1;
            stale_d = 1'b1;
         end else begin
            outst_d = 1'b0;
            stale_d = 1'b0;
         end
         if (acc) req_pc_d = fetch_pc_q;
      end else begin
         if (acc) begin
            outst_d    = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
         end
         if (rsp) begin
            outst_d = 1'b0;
            if (stale_q) begin
               stale_d = 1'b0;
            end else begin
               push = 1'b1;
               if (rsp_halt) halted_d = 1'b1;
            end
         end
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         outst_q    <= 1'b0;
         stale_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
         halted_q   <= halted_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && push) begin
         instr_q[wr_ptr_q] <= imem_resp_data;
         pc_q[wr_ptr_q]    <= req_pc_q;
         halt_q[wr_ptr_q]  <= rsp_halt;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed phases plus random traffic checked
// against a queue-based reference model and a latency memory model.
module tb_ifetch_queue;

   localparam int D = 4;
   localparam logic [31:0] RPC = 32'h100;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_halt;
   logic [2:0]  occupancy;

   ifetch_queue #(.ADDR_W(32), .DEPTH(D), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_halt(out_halt),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        halt;
   } ent_t;

   typedef struct packed {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   // Reference model: fetch queue as an SV queue plus request bookkeeping.
   ent_t        mq[$];
   mreq_t       memq[$];
   logic [31:0] m_fpc = RPC;
   logic [31:0] m_req_pc = RPC;
   bit          m_out = 0, m_stale = 0, m_halted = 0;

   bit          e_rv, e_ov, e_halt;
   logic [31:0] e_addr;
   int          e_occ;

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int cyc = 0;

   int k_ready = 100, k_ordy = 100, k_lat_lo = 1, k_lat_hi = 1;
   int k_red = 0, k_rst = 0, k_ill = 0, k_spur = 0;
   bit k_red_after_acc = 0;
   logic [31:0] k_red_pc = 32'h203;
   bit hold_rst = 1, force_red = 0, force_rst = 0, last_acc = 0;
   logic [31:0] force_pc = '0;

   logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0100011,
                             7'b0000011, 7'b1100011, 7'b1100111,
                             7'b1101111, 7'b0010111, 7'b0110111};

   function automatic bit is_halt(input logic [31:0] d);
      foreach (legal[i]) if (d[6:0] == legal[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] gen_word();
      logic [31:0] w;
      if ($urandom_range(99, 0) < k_ill) return 32'hFFFF_FFFF;
      w = $urandom;
      w[6:0] = legal[$urandom_range(8, 0)];
      return w;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic drive();
      bit r;
      r = !(hold_rst || force_rst || ($urandom_range(999, 0) < k_rst));
      force_rst = 0;
      rst = r;
      imem_req_ready = ($urandom_range(99, 0) < k_ready);
      out_ready = ($urandom_range(99, 0) < k_ordy);
      redirect_valid = 1'b0;
      redirect_pc = $urandom;
      if (force_red) begin
         redirect_valid = 1'b1;
         redirect_pc = force_pc;
         force_red = 0;
      end else if (k_red_after_acc && last_acc) begin
         redirect_valid = 1'b1;
         redirect_pc = k_red_pc;
      end else if ($urandom_range(99, 0) < k_red) begin
         redirect_valid = 1'b1;
         case ($urandom_range(3, 0))
            0:       redirect_pc = 32'hFFFF_FFF8 | $urandom_range(3, 0);
            default: redirect_pc = $urandom_range(4095, 0);
         endcase
      end
      imem_resp_valid = 1'b0;
      imem_resp_data = $urandom;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data = gen_word();
         void'(memq.pop_front());
      end else if (memq.size() == 0 && !m_out &&
                   $urandom_range(99, 0) < k_spur) begin
         imem_resp_valid = 1'b1;
      end
   endtask

   task automatic check_outputs();
      e_rv   = rst && !m_out && !m_halted && (mq.size() < D);
      e_addr = rst ? m_fpc : RPC;
      e_ov   = rst && (mq.size() > 0);
      e_occ  = rst ? mq.size() : 0;
      e_halt = e_ov ? mq[0].halt : 1'b0;
      chk("req_valid", 32'(imem_req_valid), 32'(e_rv));
      chk("req_addr", imem_req_addr, e_addr);
      chk("out_valid", 32'(out_valid), 32'(e_ov));
      chk("occupancy", 32'(occupancy), e_occ);
      chk("out_halt", 32'(out_halt), 32'(e_halt));
      if (e_ov) begin
         chk("out_pc", out_pc, mq[0].pc);
         chk("out_instr", out_instr, mq[0].instr);
      end
   endtask

   task automatic update_model();
      bit acc, rsp, pop;
      ent_t e;
      acc = e_rv && imem_req_ready;
      rsp = imem_resp_valid && m_out;
      pop = e_ov && out_ready;
      last_acc = acc;
      if (acc)
         memq.push_back('{addr: m_fpc,
                          due: cyc + $urandom_range(k_lat_hi, k_lat_lo)});
      if (!rst) begin
         mq.delete();
         m_fpc = RPC;
         m_out = 0;
         m_stale = 0;
         m_halted = 0;
      end else if (redirect_valid) begin
         mq.delete();
         m_halted = 0;
         m_fpc = {redirect_pc[31:2], 2'b00};
         m_out = acc || (m_out && !rsp);
         m_stale = m_out;
      end else begin
         if (pop) void'(mq.pop_front());
         if (rsp) begin
            m_out = 0;
            if (m_stale) begin
               m_stale = 0;
            end else begin
               e.instr = imem_resp_data;
               e.pc = m_req_pc;
               e.halt = is_halt(imem_resp_data);
               mq.push_back(e);
               if (e.halt) m_halted = 1;
            end
         end
         if (acc) begin
            m_out = 1;
            m_req_pc = m_fpc;
            m_fpc = m_fpc + 32'd4;
         end
      end
   endtask

   task automatic tick();
      drive();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      update_model();
      cyc++;
      #1;
   endtask

   initial begin
      @(posedge clk);
      #1;
      // Reset held for a few cycles.
      repeat (3) tick();
      hold_rst = 0;

      // Fast memory, decode always ready.
      repeat (30) tick();

      // Decode stalled: queue saturates and requests stop.
      k_ordy = 0;
      repeat (20) tick();
      chk("stall_occ", 32'(occupancy), 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      k_ordy = 100;
      repeat (10) tick();

      // Redirect one cycle after each acceptance with slow memory.
      k_lat_lo = 3;
      k_lat_hi = 3;
      k_red_after_acc = 1;
      repeat (12) tick();
      k_red_after_acc = 0;
      repeat (12) tick();

      // Illegal opcodes halt fetch; a redirect resumes it.
      k_lat_lo = 1;
      k_lat_hi = 1;
      k_ill = 100;
      repeat (8) tick();
      chk("halted_req_valid", 32'(imem_req_valid), 32'd0);
      k_ill = 0;
      force_red = 1;
      force_pc = 32'h40;
      repeat (10) tick();

      // Reset while a request is outstanding; late response follows.
      k_lat_lo = 3;
      k_lat_hi = 3;
      for (int i = 0; i < 20 && !m_out; i++) tick();
      force_rst = 1;
      repeat (12) tick();

      // Mixed random traffic.
      k_ready = 70;
      k_ordy = 60;
      k_lat_lo = 1;
      k_lat_hi = 4;
      k_red = 5;
      k_rst = 10;
      k_ill = 5;
      k_spur = 5;
      repeat (3000) tick();

      // Same-cycle redirect/response/pop bias.
      k_ready = 100;
      k_ordy = 50;
      k_lat_hi = 2;
      k_red = 30;
      k_rst = 0;
      k_ill = 0;
      repeat (500) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
